// File: rtl/modulo_alimentador_rolhas.sv
// Cork supply controller for the sealing stage of the filling/sealing line.
// Tracks magazine stock, reports cork availability (ro) to the filling FSM,
// and runs the refill request/delivery exchange with the external feeder.
// The alarm is raised on a feeder timeout or on a stock underflow.
// Optional build macro ROLHAS_TOTAL_EN adds the total_usadas consumed-cork counter.
module modulo_alimentador_rolhas #(
  parameter int CAPACITY   = 20,
  parameter int LOW_THRESH = 5,
  parameter int TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       ve,
  input  logic       rolha_in,
  input  logic       fault_clr,
  output logic       ro,
  output logic       req,
  output logic       al_rolhas,
  output logic [4:0] nivel,
  output logic [1:0] estado
`ifdef ROLHAS_TOTAL_EN
  ,
  output logic [7:0] total_usadas
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    FAULT  = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic [4:0] CAP_LVL = 5'(CAPACITY);
  localparam logic [4:0] LOW_LVL = 5'(LOW_THRESH);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_r, state_s;
  logic [4:0] nivel_r, nivel_s;
  logic [7:0] cnt_r, cnt_s;
  logic       ve_q_r;
  logic       underflow_r, underflow_s;
  logic       cons_s, acc_s, under_evt_s;

  // Stock arithmetic: saturate at capacity, clamp at zero and flag underflow.
  always_comb begin
    cons_s      = ve & ~ve_q_r;
    acc_s       = rolha_in & (state_r != FAULT);
    nivel_s     = nivel_r;
    under_evt_s = 1'b0;
    if (acc_s && cons_s) begin
      nivel_s = nivel_r;
    end else if (acc_s) begin
      if (nivel_r == CAP_LVL) begin
        nivel_s = CAP_LVL;
      end else begin
        nivel_s = nivel_r + 5'd1;
      end
    end else if (cons_s) begin
      if (nivel_r == 5'd0) begin
        nivel_s     = 5'd0;
        under_evt_s = 1'b1;
      end else begin
        nivel_s = nivel_r - 5'd1;
      end
    end else begin
      nivel_s = nivel_r;
    end
  end

  // Sticky underflow flag; a new underflow wins over a simultaneous acknowledge.
  always_comb begin
    underflow_s = underflow_r;
    if (under_evt_s) begin
      underflow_s = 1'b1;
    end else if (fault_clr) begin
      underflow_s = 1'b0;
    end else begin
      underflow_s = underflow_r;
    end
  end

  // Next-state logic and feeder timeout counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = 8'd0;
        if (nivel_s <= LOW_LVL) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (nivel_s == CAP_LVL) begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end else if (acc_s) begin
          state_s = REQ;
          cnt_s   = 8'd0;
        end else if (cnt_r == TO_LAST) begin
          state_s = FAULT;
          cnt_s   = 8'd0;
        end else begin
          state_s = REQ;
          cnt_s   = cnt_r + 8'd1;
        end
      end
      FAULT: begin
        cnt_s = 8'd0;
        if (fault_clr) begin
          state_s = IDLE;
        end else begin
          state_s = FAULT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // State, stock, timeout, underflow and edge-detect registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r     <= IDLE;
      nivel_r     <= 5'd0;
      cnt_r       <= 8'd0;
      ve_q_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      nivel_r     <= nivel_s;
      cnt_r       <= cnt_s;
      ve_q_r      <= ve;
      underflow_r <= underflow_s;
    end
  end

`ifdef ROLHAS_TOTAL_EN
  logic [7:0] total_r;

  // Consumed-cork counter; underflow consumptions are not counted.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      total_r <= 8'd0;
    end else if (cons_s && (nivel_r != 5'd0)) begin
      total_r <= total_r + 8'd1;
    end else begin
      total_r <= total_r;
    end
  end

  assign total_usadas = total_r;
`endif

  assign ro        = (nivel_r != 5'd0);
  assign req       = (state_r == REQ);
  assign al_rolhas = (state_r == FAULT) | underflow_r;
  assign nivel     = nivel_r;
  assign estado    = state_r;

endmodule

// File: tb/tb_modulo_alimentador_rolhas.sv
// Self-checking bench for modulo_alimentador_rolhas: directed scenarios
// followed by randomized stimulus, all checked against a behavioural model.
module tb_modulo_alimentador_rolhas;

  localparam int CAP     = 20;
  localparam int LOW     = 5;
  localparam int TMO     = 8;
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_FAULT = 2;

  logic       clk;
  logic       clr_n;
  logic       ve;
  logic       rolha_in;
  logic       fault_clr;
  logic       ro;
  logic       req;
  logic       al_rolhas;
  logic [4:0] nivel;
  logic [1:0] estado;
`ifdef ROLHAS_TOTAL_EN
  logic [7:0] total_usadas;
`endif

  int n_checks;
  int n_fail;

  // behavioural model state
  int m_nivel;
  int m_state;
  int m_wait;
  int m_under;
  int m_prev_ve;
  int m_total;

  modulo_alimentador_rolhas #(
    .CAPACITY(CAP), .LOW_THRESH(LOW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .ve(ve),
    .rolha_in(rolha_in),
    .fault_clr(fault_clr),
    .ro(ro),
    .req(req),
    .al_rolhas(al_rolhas),
    .nivel(nivel),
    .estado(estado)
`ifdef ROLHAS_TOTAL_EN
    ,
    .total_usadas(total_usadas)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nivel = 0; m_state = M_IDLE; m_wait = 0;
    m_under = 0; m_prev_ve = 0; m_total = 0;
  endtask

  // One clock of the supply rules, in stock/event terms.
  task automatic model_clock(input int v, input int r, input int f);
    int cons;
    int acc;
    int raw;
    cons = (v != 0 && m_prev_ve == 0) ? 1 : 0;
    acc  = (r != 0 && m_state != M_FAULT) ? 1 : 0;
    raw  = m_nivel + acc - cons;
    if (cons == 1 && m_nivel > 0) m_total = (m_total + 1) % 256;
    if (raw < 0) m_under = 1;
    else if (f != 0) m_under = 0;
    if (raw < 0) raw = 0;
    if (raw > CAP) raw = CAP;
    m_nivel = raw;
    if (m_state == M_IDLE) begin
      m_wait = 0;
      if (m_nivel <= LOW) m_state = M_REQ;
    end else if (m_state == M_REQ) begin
      if (m_nivel == CAP) begin
        m_state = M_IDLE; m_wait = 0;
      end else if (acc == 1) begin
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_state = M_FAULT; m_wait = 0;
        end
      end
    end else begin
      m_wait = 0;
      if (f != 0) m_state = M_IDLE;
    end
    m_prev_ve = v;
  endtask

  task automatic compare_all();
    chk("nivel", int'(nivel), m_nivel);
    chk("ro", int'(ro), (m_nivel > 0) ? 1 : 0);
    chk("req", int'(req), (m_state == M_REQ) ? 1 : 0);
    chk("al_rolhas", int'(al_rolhas), (m_state == M_FAULT || m_under != 0) ? 1 : 0);
    chk("estado", int'(estado), m_state);
`ifdef ROLHAS_TOTAL_EN
    chk("total_usadas", int'(total_usadas), m_total);
`endif
  endtask

  task automatic step(input int v, input int r, input int f);
    @(negedge clk);
    ve = v[0]; rolha_in = r[0]; fault_clr = f[0];
    model_clock(v, r, f);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0; ve = 1'b0; rolha_in = 1'b0; fault_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_req", int'(req), 0);
    chk("rst_nivel", int'(nivel), 0);
    chk("rst_estado", int'(estado), 0);
    chk("rst_al", int'(al_rolhas), 0);
    chk("rst_ro", int'(ro), 0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    clr_n = 1'b0; ve = 1'b0; rolha_in = 1'b0; fault_clr = 1'b0;
    model_reset();
    #12;
    do_reset();

    // first edge after reset arms the request
    step(0, 0, 0);
    chk("arm_estado", int'(estado), 1);
    chk("arm_req", int'(req), 1);

    // fill the magazine
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    chk("full_nivel", int'(nivel), 20);
    chk("full_req", int'(req), 0);
    chk("full_estado", int'(estado), 0);

    // 15 consumption pulses, 3 cycles high each
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    end
    chk("low_nivel", int'(nivel), 5);
    chk("low_req", int'(req), 1);
    chk("low_ro", int'(ro), 1);

    // feeder starves: 8 cycles in REQ without delivery
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("tmo_estado", int'(estado), 2);
    chk("tmo_req", int'(req), 0);
    chk("tmo_al", int'(al_rolhas), 1);
    step(0, 0, 1);
    chk("clr_estado", int'(estado), 0);
    step(0, 0, 0);
    chk("rearm_estado", int'(estado), 1);

    // drain to zero, recover, then underflow
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0); step(0, 0, 0);
    end
    chk("drain_nivel", int'(nivel), 0);
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("uf_nivel", int'(nivel), 0);
    chk("uf_al", int'(al_rolhas), 1);

    // simultaneous delivery and consumption at nivel=7
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    chk("seven_nivel", int'(nivel), 7);
    step(1, 1, 0);
    chk("both_nivel", int'(nivel), 7);
    step(0, 0, 1);
    chk("ack_al", int'(al_rolhas), 0);
    chk("ack_estado", int'(estado), 1);

    // reset in the middle of REQ
    do_reset();
    step(0, 0, 0);
    chk("rearm2_req", int'(req), 1);

`ifdef ROLHAS_TOTAL_EN
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    for (int i = 0; i < 260; i++) begin
      step(1, 1, 0); step(0, 1, 0);
    end
    chk("total_260", int'(total_usadas), 4);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int v;
      int r;
      int f;
      v = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r = ($urandom_range(0, 3) != 0) ? 1 : 0;
      f = ($urandom_range(0, 15) == 0) ? 1 : 0;
      if (v == 1 && m_prev_ve == 0 && m_nivel == 0) r = 0;
      if ($urandom_range(0, 63) == 0) r = 0;
      step(v, r, f);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
